// File: rtl/mdio_access_scheduler.sv
// Two-port round-robin scheduler that turns register accesses into Clause 22 / Clause 45 MDIO frames.
// Optional frame watchdog enabled by defining MDIO_SCHED_TIMEOUT_EN.
module mdio_access_scheduler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        clk_core,
  input  logic        sReset,
  input  logic        i_req0_valid,
  input  logic        i_req0_write,
  input  logic        i_req0_cl45,
  input  logic [4:0]  i_req0_phyaddr,
  input  logic [4:0]  i_req0_devaddr,
  input  logic [15:0] i_req0_regaddr,
  input  logic [15:0] i_req0_wdata,
  output logic        o_req0_ack,
  output logic        o_req0_done,
  output logic        o_req0_err,
  output logic [15:0] o_req0_rdata,
  input  logic        i_req1_valid,
  input  logic        i_req1_write,
  input  logic        i_req1_cl45,
  input  logic [4:0]  i_req1_phyaddr,
  input  logic [4:0]  i_req1_devaddr,
  input  logic [15:0] i_req1_regaddr,
  input  logic [15:0] i_req1_wdata,
  output logic        o_req1_ack,
  output logic        o_req1_done,
  output logic        o_req1_err,
  output logic [15:0] o_req1_rdata,
  output logic        o_mdio_en,
  output logic        o_op_write,
  output logic        o_op_read,
  output logic        o_op_addr,
  output logic        o_op_read_inc,
  output logic        o_cl45,
  output logic [4:0]  o_phyaddr,
  output logic [4:0]  o_addr,
  output logic [15:0] o_mmd,
  output logic [15:0] o_data,
  input  logic        i_mdio_done,
  input  logic [15:0] i_mdio_rdata
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE_ADDR = 3'd1,
    WAIT_ADDR  = 3'd2,
    GAP        = 3'd3,
    ISSUE_OP   = 3'd4,
    WAIT_OP    = 3'd5,
    RESP       = 3'd6
  } state_t;

  state_t      state_r;
  logic        last_r;
  logic        port_r;
  logic        write_r;
  logic        cl45_r;
  logic [4:0]  phy_r;
  logic [4:0]  dev_r;
  logic [15:0] reg_r;
  logic [15:0] wdata_r;

  logic        grant_valid_s;
  logic        grant_port_s;
  logic        sel_write_s;
  logic        sel_cl45_s;
  logic [4:0]  sel_phy_s;
  logic [4:0]  sel_dev_s;
  logic [15:0] sel_reg_s;
  logic [15:0] sel_wdata_s;
  logic        tmo_hit_s;

  // Round-robin pick: on a tie the port that was not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = ~last_r;
    end else if (i_req0_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b0;
    end else if (i_req1_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
    end
  end

  // Request field mux for the granted port.
  always_comb begin
    sel_write_s = i_req0_write;
    sel_cl45_s  = i_req0_cl45;
    sel_phy_s   = i_req0_phyaddr;
    sel_dev_s   = i_req0_devaddr;
    sel_reg_s   = i_req0_regaddr;
    sel_wdata_s = i_req0_wdata;
    if (grant_port_s) begin
      sel_write_s = i_req1_write;
      sel_cl45_s  = i_req1_cl45;
      sel_phy_s   = i_req1_phyaddr;
      sel_dev_s   = i_req1_devaddr;
      sel_reg_s   = i_req1_regaddr;
      sel_wdata_s = i_req1_wdata;
    end else begin
      sel_write_s = i_req0_write;
      sel_cl45_s  = i_req0_cl45;
      sel_phy_s   = i_req0_phyaddr;
      sel_dev_s   = i_req0_devaddr;
      sel_reg_s   = i_req0_regaddr;
      sel_wdata_s = i_req0_wdata;
    end
  end

`ifdef MDIO_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;

  // tmo_cnt_r holds the number of cycles the current frame has had en high.
  assign tmo_hit_s = ({1'b0, tmo_cnt_r} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

  // Frame watchdog counter.
  always_ff @(posedge clk_core) begin
    if (sReset) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == ISSUE_ADDR) || (state_r == ISSUE_OP)) begin
      tmo_cnt_r <= 16'd1;
    end else if ((state_r == WAIT_ADDR) || (state_r == WAIT_OP)) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= 16'd0;
    end
  end
`else
  logic [15:0] unused_tmo_cfg_s;

  assign unused_tmo_cfg_s = TIMEOUT_CYCLES;
  assign tmo_hit_s        = 1'b0;
  assign o_req0_err       = 1'b0;
  assign o_req1_err       = 1'b0;
`endif

  // Access sequencer with registered requester and master outputs.
  always_ff @(posedge clk_core) begin
    if (sReset) begin
      state_r       <= IDLE;
      last_r        <= 1'b1;
      port_r        <= 1'b0;
      write_r       <= 1'b0;
      cl45_r        <= 1'b0;
      phy_r         <= 5'd0;
      dev_r         <= 5'd0;
      reg_r         <= 16'd0;
      wdata_r       <= 16'd0;
      o_req0_ack    <= 1'b0;
      o_req1_ack    <= 1'b0;
      o_req0_done   <= 1'b0;
      o_req1_done   <= 1'b0;
      o_req0_rdata  <= 16'd0;
      o_req1_rdata  <= 16'd0;
      o_mdio_en     <= 1'b0;
      o_op_write    <= 1'b0;
      o_op_read     <= 1'b0;
      o_op_addr     <= 1'b0;
      o_op_read_inc <= 1'b0;
      o_cl45        <= 1'b0;
      o_phyaddr     <= 5'd0;
      o_addr        <= 5'd0;
      o_mmd         <= 16'd0;
      o_data        <= 16'd0;
`ifdef MDIO_SCHED_TIMEOUT_EN
      o_req0_err    <= 1'b0;
      o_req1_err    <= 1'b0;
`endif
    end else begin
      o_req0_ack    <= 1'b0;
      o_req1_ack    <= 1'b0;
      o_req0_done   <= 1'b0;
      o_req1_done   <= 1'b0;
      o_op_read_inc <= 1'b0;
`ifdef MDIO_SCHED_TIMEOUT_EN
      o_req0_err    <= 1'b0;
      o_req1_err    <= 1'b0;
`endif
      case (state_r)
        // RESP already carries the done pulse, so it arbitrates like IDLE.
        IDLE, RESP: begin
          if (grant_valid_s) begin
            last_r     <= grant_port_s;
            port_r     <= grant_port_s;
            write_r    <= sel_write_s;
            cl45_r     <= sel_cl45_s;
            phy_r      <= sel_phy_s;
            dev_r      <= sel_dev_s;
            reg_r      <= sel_reg_s;
            wdata_r    <= sel_wdata_s;
            o_req0_ack <= ~grant_port_s;
            o_req1_ack <= grant_port_s;
            o_mdio_en  <= 1'b1;
            o_phyaddr  <= sel_phy_s;
            o_addr     <= sel_dev_s;
            if (sel_cl45_s) begin
              o_op_addr  <= 1'b1;
              o_op_write <= 1'b0;
              o_op_read  <= 1'b0;
              o_cl45     <= 1'b1;
              o_mmd      <= sel_reg_s;
              o_data     <= sel_reg_s;
              state_r    <= ISSUE_ADDR;
            end else begin
              o_op_addr  <= 1'b0;
              o_op_write <= sel_write_s;
              o_op_read  <= ~sel_write_s;
              o_cl45     <= 1'b0;
              o_mmd      <= 16'd0;
              o_data     <= sel_wdata_s;
              state_r    <= ISSUE_OP;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE_ADDR: begin
          state_r <= WAIT_ADDR;
        end
        WAIT_ADDR: begin
          if (i_mdio_done) begin
            o_mdio_en <= 1'b0;
            o_op_addr <= 1'b0;
            state_r   <= GAP;
          end else if (tmo_hit_s) begin
            o_mdio_en   <= 1'b0;
            o_op_addr   <= 1'b0;
            o_req0_done <= ~port_r;
            o_req1_done <= port_r;
`ifdef MDIO_SCHED_TIMEOUT_EN
            o_req0_err  <= ~port_r;
            o_req1_err  <= port_r;
`endif
            if (port_r) begin
              o_req1_rdata <= 16'hFFFF;
            end else begin
              o_req0_rdata <= 16'hFFFF;
            end
            state_r <= RESP;
          end else begin
            state_r <= WAIT_ADDR;
          end
        end
        GAP: begin
          o_mdio_en  <= 1'b1;
          o_op_addr  <= 1'b0;
          o_op_write <= write_r;
          o_op_read  <= ~write_r;
          o_cl45     <= cl45_r;
          o_phyaddr  <= phy_r;
          o_addr     <= dev_r;
          o_mmd      <= reg_r;
          o_data     <= wdata_r;
          state_r    <= ISSUE_OP;
        end
        ISSUE_OP: begin
          state_r <= WAIT_OP;
        end
        WAIT_OP: begin
          if (i_mdio_done || tmo_hit_s) begin
            o_mdio_en   <= 1'b0;
            o_op_write  <= 1'b0;
            o_op_read   <= 1'b0;
            o_req0_done <= ~port_r;
            o_req1_done <= port_r;
            if (i_mdio_done) begin
              if (!write_r && port_r) begin
                o_req1_rdata <= i_mdio_rdata;
              end else if (!write_r) begin
                o_req0_rdata <= i_mdio_rdata;
              end else begin
                o_req0_rdata <= o_req0_rdata;
              end
            end else begin
`ifdef MDIO_SCHED_TIMEOUT_EN
              o_req0_err <= ~port_r;
              o_req1_err <= port_r;
`endif
              if (port_r) begin
                o_req1_rdata <= 16'hFFFF;
              end else begin
                o_req0_rdata <= 16'hFFFF;
              end
            end
            state_r <= RESP;
          end else begin
            state_r <= WAIT_OP;
          end
        end
        default: begin
          o_mdio_en  <= 1'b0;
          o_op_write <= 1'b0;
          o_op_read  <= 1'b0;
          o_op_addr  <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_access_scheduler.sv
// Directed bench for mdio_access_scheduler: vector table of accesses plus arbitration, reset and watchdog sequences.
`timescale 1ns/1ps
module tb_mdio_access_scheduler;

  logic        clk_core = 1'b0;
  logic        sReset;
  logic        i_req0_valid, i_req0_write, i_req0_cl45;
  logic [4:0]  i_req0_phyaddr, i_req0_devaddr;
  logic [15:0] i_req0_regaddr, i_req0_wdata;
  logic        o_req0_ack, o_req0_done, o_req0_err;
  logic [15:0] o_req0_rdata;
  logic        i_req1_valid, i_req1_write, i_req1_cl45;
  logic [4:0]  i_req1_phyaddr, i_req1_devaddr;
  logic [15:0] i_req1_regaddr, i_req1_wdata;
  logic        o_req1_ack, o_req1_done, o_req1_err;
  logic [15:0] o_req1_rdata;
  logic        o_mdio_en, o_op_write, o_op_read, o_op_addr, o_op_read_inc, o_cl45;
  logic [4:0]  o_phyaddr, o_addr;
  logic [15:0] o_mmd, o_data;
  logic        i_mdio_done;
  logic [15:0] i_mdio_rdata;

  always #5 clk_core = ~clk_core;

  mdio_access_scheduler #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk_core(clk_core), .sReset(sReset),
    .i_req0_valid(i_req0_valid), .i_req0_write(i_req0_write), .i_req0_cl45(i_req0_cl45),
    .i_req0_phyaddr(i_req0_phyaddr), .i_req0_devaddr(i_req0_devaddr),
    .i_req0_regaddr(i_req0_regaddr), .i_req0_wdata(i_req0_wdata),
    .o_req0_ack(o_req0_ack), .o_req0_done(o_req0_done), .o_req0_err(o_req0_err),
    .o_req0_rdata(o_req0_rdata),
    .i_req1_valid(i_req1_valid), .i_req1_write(i_req1_write), .i_req1_cl45(i_req1_cl45),
    .i_req1_phyaddr(i_req1_phyaddr), .i_req1_devaddr(i_req1_devaddr),
    .i_req1_regaddr(i_req1_regaddr), .i_req1_wdata(i_req1_wdata),
    .o_req1_ack(o_req1_ack), .o_req1_done(o_req1_done), .o_req1_err(o_req1_err),
    .o_req1_rdata(o_req1_rdata),
    .o_mdio_en(o_mdio_en), .o_op_write(o_op_write), .o_op_read(o_op_read),
    .o_op_addr(o_op_addr), .o_op_read_inc(o_op_read_inc), .o_cl45(o_cl45),
    .o_phyaddr(o_phyaddr), .o_addr(o_addr), .o_mmd(o_mmd), .o_data(o_data),
    .i_mdio_done(i_mdio_done), .i_mdio_rdata(i_mdio_rdata)
  );

  // Op encoding {addr, write, read}
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_ADDR  = 3'b100;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_READ  = 3'b001;

  typedef struct {
    logic        port;
    logic        write;
    logic        cl45;
    logic [4:0]  phy;
    logic [4:0]  dev;
    logic [15:0] regaddr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    int          nfr;
    logic [2:0]  f1_op;
    logic [15:0] f1_data;
    logic [2:0]  f2_op;
    logic [15:0] f2_data;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];
  int checks = 0;
  int errors = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk16(name, 16'(act), 16'(exp));
  endtask

  function automatic logic any_output();
    return |{o_req0_ack, o_req0_done, o_req0_err, o_req0_rdata,
             o_req1_ack, o_req1_done, o_req1_err, o_req1_rdata,
             o_mdio_en, o_op_write, o_op_read, o_op_addr, o_op_read_inc, o_cl45,
             o_phyaddr, o_addr, o_mmd, o_data};
  endfunction

  task automatic set_req(input logic port, input vec_t v, input logic vld);
    if (port) begin
      i_req1_valid = vld; i_req1_write = v.write; i_req1_cl45 = v.cl45;
      i_req1_phyaddr = v.phy; i_req1_devaddr = v.dev;
      i_req1_regaddr = v.regaddr; i_req1_wdata = v.wdata;
    end else begin
      i_req0_valid = vld; i_req0_write = v.write; i_req0_cl45 = v.cl45;
      i_req0_phyaddr = v.phy; i_req0_devaddr = v.dev;
      i_req0_regaddr = v.regaddr; i_req0_wdata = v.wdata;
    end
  endtask

  task automatic chk_frame(input string name, input vec_t v, input logic [2:0] op, input logic [15:0] data);
    chk1({name, "_en"}, o_mdio_en, 1'b1);
    chk16({name, "_op"}, 16'({o_op_addr, o_op_write, o_op_read}), 16'(op));
    chk1({name, "_inc"}, o_op_read_inc, 1'b0);
    chk16({name, "_data"}, o_data, data);
    chk16({name, "_addr"}, 16'(o_addr), 16'(v.dev));
    chk16({name, "_phy"}, 16'(o_phyaddr), 16'(v.phy));
    chk1({name, "_cl45"}, o_cl45, v.cl45);
  endtask

  task automatic pulse_done(input logic [15:0] rd);
    i_mdio_done = 1'b1;
    i_mdio_rdata = rd;
    @(negedge clk_core);
    i_mdio_done = 1'b0;
    i_mdio_rdata = 16'h0000;
  endtask

  task automatic do_access(input vec_t v);
    @(negedge clk_core);
    set_req(v.port, v, 1'b1);
    @(negedge clk_core);
    chk1("ack", v.port ? o_req1_ack : o_req0_ack, 1'b1);
    chk1("ack_other", v.port ? o_req0_ack : o_req1_ack, 1'b0);
    chk_frame("f1", v, v.f1_op, v.f1_data);
    set_req(v.port, v, 1'b0);
    repeat (3) @(negedge clk_core);
    chk_frame("f1_hold", v, v.f1_op, v.f1_data);
    chk1("early_done", o_req0_done | o_req1_done, 1'b0);
    if (v.nfr == 2) begin
      pulse_done(16'hDEAD);
      chk1("gap_en", o_mdio_en, 1'b0);
      chk16("gap_op", 16'({o_op_addr, o_op_write, o_op_read}), 16'(OP_NONE));
      chk1("gap_done", o_req0_done | o_req1_done, 1'b0);
      @(negedge clk_core);
      chk_frame("f2", v, v.f2_op, v.f2_data);
      chk16("f2_mmd", o_mmd, v.regaddr);
      repeat (2) @(negedge clk_core);
      chk_frame("f2_hold", v, v.f2_op, v.f2_data);
    end
    pulse_done(v.mrdata);
    chk1("end_en", o_mdio_en, 1'b0);
    chk16("end_op", 16'({o_op_addr, o_op_write, o_op_read}), 16'(OP_NONE));
    chk1("done", v.port ? o_req1_done : o_req0_done, 1'b1);
    chk1("done_other", v.port ? o_req0_done : o_req1_done, 1'b0);
    chk1("err", v.port ? o_req1_err : o_req0_err, 1'b0);
    chk16("rdata", v.port ? o_req1_rdata : o_req0_rdata, v.exp_rdata);
    @(negedge clk_core);
    chk1("done_pulse", o_req0_done | o_req1_done, 1'b0);
  endtask

  logic exp_order [4];
  int   n;

  initial begin
    // port wr cl45 phy dev reg wdata mrdata nfr f1_op f1_data f2_op f2_data exp_rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd5,  5'd2,  16'h0000, 16'h0000, 16'h0141, 1, OP_READ,  16'h0000, OP_NONE,  16'h0000, 16'h0141};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd1,  5'd3,  16'h0800, 16'hA5A5, 16'h1234, 2, OP_ADDR,  16'h0800, OP_WRITE, 16'hA5A5, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 16'hFFFF, 16'h0000, 16'hBEEF, 2, OP_ADDR,  16'hFFFF, OP_READ,  16'h0000, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  16'h1234, 16'h5A5A, 16'hDEAD, 1, OP_WRITE, 16'h5A5A, OP_NONE,  16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd3,  5'd1,  16'h0000, 16'h0000, 16'h8001, 1, OP_READ,  16'h0000, OP_NONE,  16'h0000, 16'h8001};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd2,  5'd4,  16'h0000, 16'h0F0F, 16'h7777, 1, OP_WRITE, 16'h0F0F, OP_NONE,  16'h0000, 16'hBEEF};
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    sReset = 1'b1;
    set_req(1'b0, vecs[0], 1'b0);
    set_req(1'b1, vecs[0], 1'b0);
    i_mdio_done = 1'b0;
    i_mdio_rdata = 16'h0000;
    repeat (3) @(negedge clk_core);
    chk1("reset_outputs", any_output(), 1'b0);
    sReset = 1'b0;
    @(negedge clk_core);
    chk1("idle_outputs", any_output(), 1'b0);

    // Both ports held valid from reset: grants must alternate starting with port 0.
    set_req(1'b0, vecs[0], 1'b1);
    set_req(1'b1, vecs[4], 1'b1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(o_req0_ack || o_req1_ack) && n < 20) begin
        @(negedge clk_core);
        n++;
      end
      chk1("arb_ack_seen", o_req0_ack | o_req1_ack, 1'b1);
      chk1("arb_order", o_req1_ack, exp_order[k]);
      if (k == 3) begin
        set_req(1'b0, vecs[0], 1'b0);
        set_req(1'b1, vecs[4], 1'b0);
      end
      repeat (2) @(negedge clk_core);
      pulse_done(16'h0000);
    end
    @(negedge clk_core);
    chk1("arb_idle_en", o_mdio_en, 1'b0);

    // Spurious master done while idle must be ignored.
    pulse_done(16'h5555);
    chk1("spur_en", o_mdio_en, 1'b0);
    chk1("spur_done", o_req0_done | o_req1_done, 1'b0);
    chk1("spur_ack", o_req0_ack | o_req1_ack, 1'b0);
    @(negedge clk_core);
    chk1("spur_done2", o_req0_done | o_req1_done, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i]);
    end

`ifdef MDIO_SCHED_TIMEOUT_EN
    // Watchdog: no master done, frame aborted after 16 enabled cycles.
    @(negedge clk_core);
    set_req(1'b1, vecs[4], 1'b1);
    @(negedge clk_core);
    chk1("tmo_ack", o_req1_ack, 1'b1);
    set_req(1'b1, vecs[4], 1'b0);
    n = 1;
    while (o_mdio_en && n < 100) begin
      @(negedge clk_core);
      if (o_mdio_en) n++;
    end
    chk16("tmo_en_cycles", 16'(n), 16'd16);
    chk1("tmo_done", o_req1_done, 1'b1);
    chk1("tmo_err", o_req1_err, 1'b1);
    chk16("tmo_rdata", o_req1_rdata, 16'hFFFF);
`else
    // Without the watchdog a frame stays enabled until the master answers.
    @(negedge clk_core);
    set_req(1'b1, vecs[4], 1'b1);
    @(negedge clk_core);
    chk1("wait_ack", o_req1_ack, 1'b1);
    set_req(1'b1, vecs[4], 1'b0);
    repeat (40) @(negedge clk_core);
    chk1("wait_en", o_mdio_en, 1'b1);
    chk1("wait_done", o_req1_done, 1'b0);
    pulse_done(16'h1357);
    chk1("wait_final_done", o_req1_done, 1'b1);
    chk1("wait_err", o_req1_err, 1'b0);
    chk16("wait_rdata", o_req1_rdata, 16'h1357);
`endif
    @(negedge clk_core);

    // Reset in the middle of a Clause 45 address frame.
    set_req(1'b0, vecs[2], 1'b1);
    @(negedge clk_core);
    chk1("rst_ack", o_req0_ack, 1'b1);
    set_req(1'b0, vecs[2], 1'b0);
    repeat (3) @(negedge clk_core);
    chk1("rst_pre_en", o_mdio_en, 1'b1);
    sReset = 1'b1;
    @(negedge clk_core);
    sReset = 1'b0;
    chk1("rst_mid_outputs", any_output(), 1'b0);
    n = 0;
    repeat (5) begin
      @(negedge clk_core);
      if (o_req0_done || o_req1_done || o_mdio_en) n++;
    end
    chk16("rst_no_activity", 16'(n), 16'd0);
    do_access(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_access_scheduler.md
# mdio_access_scheduler

Shares one MDIO master between two requesters (e.g. PHY init sequencer and software register port) and sequences complete register accesses on it. Round-robin arbitration; each accepted request becomes one Clause 22 frame or a Clause 45 ADDRESS frame followed by a WRITE or READ frame. Sits between the requesters and the MDIO master in the `clk_core` domain.

## Interface
- `TIMEOUT_CYCLES`, default 4096: `clk_core` cycles a frame may stay enabled before abort (width 16).
- `clk_core`  in  1  core clock, same clock as MDIO master core.
- `sReset`  in  1  reset; one clock, reset synchronous and active-high.
- `i_reqN_valid`  in  1  (N=0,1) request pending; held with fields until ack.
- `i_reqN_write`  in  1  1 = write, 0 = read.
- `i_reqN_cl45`  in  1  1 = Clause 45 access.
- `i_reqN_phyaddr`  in  5  PHY/port address.
- `i_reqN_devaddr`  in  5  CL22 register address / CL45 MMD device address.
- `i_reqN_regaddr`  in  16  CL45 register address (ignored for CL22).
- `i_reqN_wdata`  in  16  write data.
- `o_reqN_ack`  out  1  one-cycle pulse: request captured.
- `o_reqN_done`  out  1  one-cycle pulse: access finished.
- `o_reqN_err`  out  1  valid with done: frame timed out.
- `o_reqN_rdata`  out  16  read result, updated only at done of a read.
- `o_mdio_en`, `o_op_write`, `o_op_read`, `o_op_addr`, `o_op_read_inc`, `o_cl45`  out  1  master controls.
- `o_phyaddr`, `o_addr`  out  5  master address fields.
- `o_mmd`, `o_data`  out  16  master MMD register address / data field.
- `i_mdio_done`  in  1  one-cycle pulse from master: frame complete.
- `i_mdio_rdata`  in  16  master read data, valid with `i_mdio_done`.

## Operation
- States: IDLE, ISSUE_ADDR, WAIT_ADDR, GAP, ISSUE_OP, WAIT_OP, RESP.
- IDLE: if any valid, grant by round-robin; pointer `last` resets to 1, so req0 wins the first tie; grant toggles `last`. Capture fields, pulse ack.
- CL22 -> ISSUE_OP; CL45 -> ISSUE_ADDR.
- ISSUE_ADDR: `o_mdio_en`=1, `o_op_addr`=1, `o_cl45`=1, `o_addr`=devaddr, `o_mmd`=`o_data`=regaddr -> WAIT_ADDR.
- WAIT_ADDR: hold all master outputs; on `i_mdio_done` -> GAP (en low one cycle) -> ISSUE_OP.
- ISSUE_OP: `o_mdio_en`=1, exactly one of `o_op_write`/`o_op_read`; `o_data`=wdata; CL22 `o_addr`=devaddr -> WAIT_OP.
- WAIT_OP: on `i_mdio_done` capture `i_mdio_rdata` if read -> RESP.
- RESP: pulse done for granted port, err=0 -> IDLE.
- `o_op_read_inc` always 0. Exactly one op bit high whenever `o_mdio_en`=1; all op bits 0 when en=0.
- Master outputs stable from ISSUE_* through the done cycle.
- `i_mdio_done` outside WAIT_* ignored.
- Requester dropping valid before ack: not captured, no ack.
- Reset mid-access: return to IDLE immediately, in-flight request dropped with no done; requester re-issues.

## Timing
- All outputs registered; reset value 0 for every output, `last`=1.
- Valid seen in IDLE at cycle T: ack and `o_mdio_en` both high at T+1.
- Done pulse at D: `o_mdio_en` low at D+1; CL45 second frame en high at D+2.
- Final done at K: `o_reqN_done` at K+1; next grant evaluated at K+1, en high at K+2.
- Back-to-back requests from both ports alternate 0,1,0,1.

## Configuration
- `MDIO_SCHED_TIMEOUT_EN` defined: 16-bit counter runs while in WAIT_*; at count `TIMEOUT_CYCLES` drop en, go to RESP with err=1, `o_reqN_rdata`=16'hFFFF, remaining CL45 frame skipped. `i_mdio_done` and timeout in same cycle: done wins, err=0.
- Undefined: no counter, WAIT_* wait indefinitely, `o_reqN_err` tied 0.

## Test plan
- CL22 read req0, phy 5, reg 2, master returns 16'h0141 -> one frame `o_op_read`=1 `o_addr`=2; `o_req0_done` with rdata 16'h0141, err 0.
- CL45 write req1, phy 1, dev 3, reg 16'h0800, data 16'hA5A5 -> ADDRESS frame (`o_data`=16'h0800), one-cycle en gap, WRITE frame (`o_data`=16'hA5A5); single done.
- Both valid same cycle after reset -> req0 acked first, req1 next; repeat -> order 0,1,0,1.
- With `MDIO_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no `i_mdio_done` -> en drops after 16 cycles; done with err=1, rdata 16'hFFFF.
- `sReset` during WAIT_ADDR -> next cycle all outputs 0, no done; subsequent request served normally.
- Spurious `i_mdio_done` in IDLE -> no state change, no done pulse.
